// File: rtl/seq_divider_fourbit.sv
// Sequential restoring divider for unsigned operands.
// Produces one quotient bit per clock by trial subtraction.
// The start/done handshake and the result bus outputs are all registered.
// A zero divisor is reported through div_by_zero with a one-edge latency.
module seq_divider_fourbit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    // The iteration counter must be able to hold WIDTH itself.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Working registers: D shifts out dividend bits, V is the divisor,
    // R is the partial remainder and Q collects quotient bits.
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] d_next;
    logic [WIDTH-1:0] v_reg;
    logic [WIDTH-1:0] v_next;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;

    // Next values of the registered outputs.
    logic             busy_next;
    logic             done_next;
    logic [WIDTH-1:0] quotient_next;
    logic [WIDTH-1:0] remainder_next;
    logic             div_by_zero_next;

    // One iteration of the restoring step.
    // The partial remainder is always below 2^(i-1) before step i, so the
    // left shift never loses a set bit and R fits in WIDTH bits.
    logic [WIDTH-1:0] r_shifted;
    logic [WIDTH:0]   trial;

    // Trial subtraction at WIDTH+1 bits; its MSB is the borrow that decides
    // whether this quotient bit is 1 (no borrow) or 0 (restore).
    always_comb begin
        r_shifted = {r_reg[WIDTH-2:0], d_reg[WIDTH-1]};
        trial     = {1'b0, r_shifted} - {1'b0, v_reg};
    end

    // Next-state logic and datapath updates for each FSM state.
    always_comb begin
        state_next       = state;
        d_next           = d_reg;
        v_next           = v_reg;
        r_next           = r_reg;
        q_next           = q_reg;
        count_next       = count_reg;
        busy_next        = busy;
        done_next        = 1'b0;
        quotient_next    = quotient;
        remainder_next   = remainder;
        div_by_zero_next = div_by_zero;

        case (state)
            IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        d_next           = dividend;
                        v_next           = divisor;
                        r_next           = '0;
                        q_next           = '0;
                        count_next       = CW'(WIDTH);
                        div_by_zero_next = 1'b0;
                        busy_next        = 1'b1;
                        state_next       = RUN;
                    end else begin
                        // Division by zero skips the iterations entirely;
                        // the result is staged in Q/R and published in DONE.
                        q_next           = '1;
                        r_next           = dividend;
                        div_by_zero_next = 1'b1;
                        state_next       = DONE;
                    end
                end
            end

            RUN: begin
                d_next = {d_reg[WIDTH-2:0], 1'b0};
                if (!trial[WIDTH]) begin
                    r_next = trial[WIDTH-1:0];
                    q_next = {q_reg[WIDTH-2:0], 1'b1};
                end else begin
                    r_next = r_shifted;
                    q_next = {q_reg[WIDTH-2:0], 1'b0};
                end
                count_next = count_reg - CW'(1);
                if (count_reg == CW'(1)) begin
                    state_next = DONE;
                end
            end

            DONE: begin
                quotient_next  = q_reg;
                remainder_next = r_reg;
                done_next      = 1'b1;
                busy_next      = 1'b0;
                state_next     = IDLE;
            end

            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    // State, working registers and outputs; reset clears everything at once
    // and abandons any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            d_reg       <= '0;
            v_reg       <= '0;
            r_reg       <= '0;
            q_reg       <= '0;
            count_reg   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_next;
            d_reg       <= d_next;
            v_reg       <= v_next;
            r_reg       <= r_next;
            q_reg       <= q_next;
            count_reg   <= count_next;
            busy        <= busy_next;
            done        <= done_next;
            quotient    <= quotient_next;
            remainder   <= remainder_next;
            div_by_zero <= div_by_zero_next;
        end
    end

endmodule
